// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM state encoding, instruction field
// positions and the opcode values the main control decoder recognises.
package mips_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE  = 2'd0,
    IFU_REQ   = 2'd1,
    IFU_DRAIN = 2'd2,
    IFU_HOLD  = 2'd3
  } ifuState_e;

  localparam int OPCODE_MSB  = 31;
  localparam int OPCODE_LSB  = 26;
  localparam int INSTR_BYTES = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: async-reset register that loads a word-aligned redirect
// target, steps by one instruction, or holds. A load beats an increment.
module pc_reg
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              loadTarget,
  input  logic              increment,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (loadTarget) begin
      pc <= {target[ADDR_W-1:2], 2'b00};
    end else if (increment) begin
      pc <= pc + ADDR_W'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, a single held
// instruction for decode, and redirect with stale-fetch discard.
// Optional stall counter output enabled by defining IFU_STALL_COUNTER_EN.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic [31:0]       imemRdata,
  input  logic              imemAck,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] pcOut,
  output logic [ADDR_W-1:0] pcPlus4,
  output logic              instrValid,
  input  logic              instrReady,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirectTarget
`ifdef IFU_STALL_COUNTER_EN
  ,
  output logic [31:0]       stallCycles
`endif
);

  ifuState_e         stateReg, stateNext;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] drainAddrReg;
  logic [31:0]       instrReg;
  logic [ADDR_W-1:0] pcOutReg;
  logic              loadTarget, increment, capture;

  pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) uPcReg (
    .clk        (clk),
    .reset      (reset),
    .loadTarget (loadTarget),
    .increment  (increment),
    .target     (redirectTarget),
    .pc         (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateReg <= IFU_IDLE;
    else       stateReg <= stateNext;
  end

  // A redirect always retargets pc, whatever the state; it also vetoes capture.
  always_comb begin
    stateNext  = stateReg;
    loadTarget = redirect;
    increment  = 1'b0;
    capture    = 1'b0;
    case (stateReg)
      IFU_IDLE:  stateNext = IFU_REQ;
      IFU_REQ: begin
        if (redirect) begin
          stateNext = imemAck ? IFU_REQ : IFU_DRAIN;
        end else if (imemAck) begin
          capture   = 1'b1;
          increment = 1'b1;
          stateNext = IFU_HOLD;
        end
      end
      IFU_DRAIN: if (imemAck) stateNext = IFU_REQ;
      IFU_HOLD:  if (redirect || instrReady) stateNext = IFU_REQ;
      default:   stateNext = IFU_IDLE;
    endcase
  end

  // drainAddrReg shadows pc while requesting so DRAIN keeps presenting the old address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drainAddrReg <= RESET_PC;
      instrReg     <= '0;
      pcOutReg     <= RESET_PC;
    end else begin
      if (stateReg == IFU_REQ) drainAddrReg <= pc;
      if (capture) begin
        instrReg <= imemRdata;
        pcOutReg <= pc;
      end
    end
  end

  assign imemReq    = (stateReg == IFU_REQ) || (stateReg == IFU_DRAIN);
  assign imemAddr   = (stateReg == IFU_DRAIN) ? drainAddrReg : pc;
  assign instrValid = (stateReg == IFU_HOLD);
  assign instr      = instrReg;
  assign opcode     = instrReg[OPCODE_MSB:OPCODE_LSB];
  assign pcOut      = pcOutReg;
  assign pcPlus4    = pcOutReg + ADDR_W'(INSTR_BYTES);

`ifdef IFU_STALL_COUNTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCycles <= '0;
    end else if (((imemReq && !imemAck) || (stateReg == IFU_HOLD && !instrReady))
                 && (stallCycles != 32'hFFFF_FFFF)) begin
      stallCycles <= stallCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized
// run scored against a transaction-level model of the fetch stream.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        imemAck;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pcOut;
  logic [31:0] pcPlus4;
  logic        instrValid;
  logic        instrReady;
  logic        redirect;
  logic [31:0] redirectTarget;
`ifdef IFU_STALL_COUNTER_EN
  logic [31:0] stallCycles;
`endif

  int nChecks = 0;
  int nFails  = 0;
  int fixedLat = 1;
  int curLat   = 1;
  int ackCnt   = 0;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0040)) dut (
    .clk            (clk),
    .reset          (reset),
    .imemReq        (imemReq),
    .imemAddr       (imemAddr),
    .imemRdata      (imemRdata),
    .imemAck        (imemAck),
    .instr          (instr),
    .opcode         (opcode),
    .pcOut          (pcOut),
    .pcPlus4        (pcPlus4),
    .instrValid     (instrValid),
    .instrReady     (instrReady),
    .redirect       (redirect),
    .redirectTarget (redirectTarget)
`ifdef IFU_STALL_COUNTER_EN
    ,
    .stallCycles    (stallCycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h8C01_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory responder: acks after curLat cycles of a held request, one-cycle strobe.
  always @(posedge clk) begin
    #2;
    if (imemAck) begin
      imemAck = 1'b0;
      ackCnt  = 0;
    end else if (imemReq && !reset) begin
      if (ackCnt == 0) curLat = (fixedLat != 0) ? fixedLat : int'($urandom_range(1, 4));
      ackCnt++;
      if (ackCnt >= curLat) begin
        imemAck   = 1'b1;
        imemRdata = memWord(imemAddr);
      end
    end else begin
      ackCnt = 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (instrValid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic waitReq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (imemReq) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; instrReady = 1'b0; redirect = 1'b0; redirectTarget = '0;
    imemAck = 1'b0; imemRdata = '0;
    step(); step();
    nChecks++;
    if (imemReq !== 1'b0 || instrValid !== 1'b0) begin
      nFails++; $display("FAIL reset_ctrl: imemReq=%b instrValid=%b required 0 0", imemReq, instrValid);
    end
    nChecks++;
    if (instr !== 32'h0 || pcOut !== 32'h40 || pcPlus4 !== 32'h44) begin
      nFails++; $display("FAIL reset_data: instr=%h pcOut=%h pcPlus4=%h required 0 40 44", instr, pcOut, pcPlus4);
    end
`ifdef IFU_STALL_COUNTER_EN
    nChecks++;
    if (stallCycles !== 32'h0) begin
      nFails++; $display("FAIL reset_stall: stallCycles=%0d required 0", stallCycles);
    end
`endif
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_first_fetch();
    bit ok;
    fixedLat = 1;
    waitReq(ok);
    nChecks++;
    if (!ok || imemAddr !== 32'h40) begin
      nFails++; $display("FAIL first_addr: req=%b addr=%h required 1 40", ok, imemAddr);
    end
    waitValid(ok);
    nChecks++;
    if (!ok || instr !== 32'h8C01_0004 || opcode !== 6'b100011 || pcOut !== 32'h40 || pcPlus4 !== 32'h44) begin
      nFails++; $display("FAIL first_instr: valid=%b instr=%h op=%b pc=%h pc4=%h required 1 8c010004 100011 40 44",
                         ok, instr, opcode, pcOut, pcPlus4);
    end
    $display("test_first_fetch done: pc=%h instr=%h", pcOut, instr);
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] heldPc, heldInstr;
`ifdef IFU_STALL_COUNTER_EN
    logic [31:0] stall0;
    stall0 = stallCycles;
`endif
    heldPc = pcOut; heldInstr = instr;
    instrReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      nChecks++;
      if (instrValid !== 1'b1 || pcOut !== heldPc || instr !== heldInstr || imemReq !== 1'b0) begin
        nFails++; $display("FAIL hold_stable[%0d]: valid=%b pc=%h instr=%h req=%b required 1 %h %h 0",
                           i, instrValid, pcOut, instr, imemReq, heldPc, heldInstr);
      end
    end
`ifdef IFU_STALL_COUNTER_EN
    nChecks++;
    if (stallCycles !== stall0 + 32'd5) begin
      nFails++; $display("FAIL hold_stall: stallCycles=%0d required %0d", stallCycles, stall0 + 32'd5);
    end
`endif
    instrReady = 1'b1;
    step();
    instrReady = 1'b0;
    nChecks++;
    if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== heldPc + 32'd4) begin
      nFails++; $display("FAIL accept_next: valid=%b req=%b addr=%h required 0 1 %h", instrValid, imemReq, imemAddr, heldPc + 32'd4);
    end
    waitValid(ok);
    nChecks++;
    if (!ok || pcOut !== 32'h44 || instr !== memWord(32'h44)) begin
      nFails++; $display("FAIL second_instr: valid=%b pc=%h instr=%h required 1 44 %h", ok, pcOut, instr, memWord(32'h44));
    end
    $display("test_backpressure done: pc=%h", pcOut);
  endtask

  task automatic test_redirect_drain();
    bit ok, sawOldAck, found, sawValid;
    fixedLat = 3;
    instrReady = 1'b1;
    step();
    instrReady = 1'b0;
    redirect = 1'b1; redirectTarget = 32'h100;
    step();
    redirect = 1'b0;
    nChecks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h48) begin
      nFails++; $display("FAIL drain_addr: req=%b addr=%h required 1 48", imemReq, imemAddr);
    end
    sawOldAck = 1'b0; found = 1'b0; sawValid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #3;
      if (imemAck && imemAddr == 32'h48) sawOldAck = 1'b1;
      if (instrValid) sawValid = 1'b1;
      if (imemReq && imemAddr == 32'h100) begin found = 1'b1; break; end
    end
    nChecks++;
    if (!sawOldAck || sawValid || !found) begin
      nFails++; $display("FAIL drain_discard: oldAck=%b valid=%b newReq=%b required 1 0 1", sawOldAck, sawValid, found);
    end
    waitValid(ok);
    nChecks++;
    if (!ok || pcOut !== 32'h100 || instr !== memWord(32'h100)) begin
      nFails++; $display("FAIL redirect_instr: valid=%b pc=%h instr=%h required 1 100 %h", ok, pcOut, instr, memWord(32'h100));
    end
    $display("test_redirect_drain done: pc=%h", pcOut);
  endtask

  task automatic test_align();
    bit ok;
    fixedLat = 1;
    instrReady = 1'b1; redirect = 1'b1; redirectTarget = 32'h203;
    step();
    instrReady = 1'b0; redirect = 1'b0;
    nChecks++;
    if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h200) begin
      nFails++; $display("FAIL align_addr: valid=%b req=%b addr=%h required 0 1 200", instrValid, imemReq, imemAddr);
    end
    waitValid(ok);
    nChecks++;
    if (!ok || pcOut !== 32'h200) begin
      nFails++; $display("FAIL align_instr: valid=%b pc=%h required 1 200", ok, pcOut);
    end
    $display("test_align done: pc=%h", pcOut);
  endtask

  task automatic test_wrap();
    bit ok;
    redirect = 1'b1; redirectTarget = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    waitValid(ok);
    nChecks++;
    if (!ok || pcOut !== 32'hFFFF_FFFC || pcPlus4 !== 32'h0 || instr !== memWord(32'hFFFF_FFFC)) begin
      nFails++; $display("FAIL wrap_instr: valid=%b pc=%h pc4=%h required 1 fffffffc 0", ok, pcOut, pcPlus4);
    end
    instrReady = 1'b1;
    step();
    instrReady = 1'b0;
    nChecks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      nFails++; $display("FAIL wrap_addr: req=%b addr=%h required 1 0", imemReq, imemAddr);
    end
    waitValid(ok);
    nChecks++;
    if (!ok || pcOut !== 32'h0) begin
      nFails++; $display("FAIL wrap_next: valid=%b pc=%h required 1 0", ok, pcOut);
    end
    $display("test_wrap done: pc=%h", pcOut);
  endtask

  task automatic test_async_reset();
    bit ok;
    fixedLat = 4;
    instrReady = 1'b1;
    step();
    instrReady = 1'b0;
    redirect = 1'b1; redirectTarget = 32'h300;
    step();
    redirect = 1'b0;
    nChecks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h4) begin
      nFails++; $display("FAIL pre_reset_drain: req=%b addr=%h required 1 4", imemReq, imemAddr);
    end
    #2;
    reset = 1'b1;
    #1;
    nChecks++;
    if (imemReq !== 1'b0 || instrValid !== 1'b0 || pcOut !== 32'h40 || instr !== 32'h0) begin
      nFails++; $display("FAIL async_reset: req=%b valid=%b pc=%h instr=%h required 0 0 40 0", imemReq, instrValid, pcOut, instr);
    end
`ifdef IFU_STALL_COUNTER_EN
    nChecks++;
    if (stallCycles !== 32'h0) begin
      nFails++; $display("FAIL async_reset_stall: stallCycles=%0d required 0", stallCycles);
    end
`endif
    step(); step();
    reset = 1'b0;
    fixedLat = 1;
    waitReq(ok);
    nChecks++;
    if (!ok || imemAddr !== 32'h40) begin
      nFails++; $display("FAIL restart_addr: req=%b addr=%h required 1 40", ok, imemAddr);
    end
    waitValid(ok);
    nChecks++;
    if (!ok || pcOut !== 32'h40 || opcode !== 6'b100011) begin
      nFails++; $display("FAIL restart_instr: valid=%b pc=%h op=%b required 1 40 100011", ok, pcOut, opcode);
    end
    $display("test_async_reset done: pc=%h", pcOut);
  endtask

  // Model: the next instruction delivered must be at expPc; a redirect sets it to
  // the aligned target, an accept advances it by one word.
  task automatic test_random();
    logic [31:0] expPc, prevPc, prevInstr, prevAddr, tgtIn, w, r;
    logic        prevValid, prevReq, readyIn, redirIn, ackAtEdge;
    int          delivered;
`ifdef IFU_STALL_COUNTER_EN
    logic [31:0] expStall;
    expStall = '0;
`endif
    fixedLat = 0;
    instrReady = 1'b0; redirect = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    expPc = 32'h40; delivered = 0;
    prevValid = 1'b0; prevReq = 1'b0; prevPc = pcOut; prevInstr = instr; prevAddr = imemAddr;
    readyIn = 1'b0; redirIn = 1'b0; tgtIn = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      ackAtEdge = imemAck;
      if (redirIn) expPc = {tgtIn[31:2], 2'b00};
      else if (prevValid && readyIn) expPc = prevPc + 32'd4;
      if (instrValid && !prevValid) begin
        delivered++;
        w = memWord(expPc);
        nChecks++;
        if (pcOut !== expPc || instr !== w || opcode !== w[31:26] || pcPlus4 !== expPc + 32'd4) begin
          nFails++; $display("FAIL rnd_deliver@%0d: pc=%h instr=%h op=%b pc4=%h required %h %h %b %h",
                             cyc, pcOut, instr, opcode, pcPlus4, expPc, w, w[31:26], expPc + 32'd4);
        end
      end
      if (prevValid) begin
        nChecks++;
        if (readyIn || redirIn) begin
          if (instrValid !== 1'b0 || imemReq !== 1'b1) begin
            nFails++; $display("FAIL rnd_release@%0d: valid=%b req=%b required 0 1", cyc, instrValid, imemReq);
          end
        end else if (instrValid !== 1'b1 || pcOut !== prevPc || instr !== prevInstr || imemReq !== 1'b0) begin
          nFails++; $display("FAIL rnd_hold@%0d: valid=%b pc=%h instr=%h req=%b required 1 %h %h 0",
                             cyc, instrValid, pcOut, instr, imemReq, prevPc, prevInstr);
        end
      end
      if (prevReq && imemReq && !ackAtEdge) begin
        nChecks++;
        if (imemAddr !== prevAddr) begin
          nFails++; $display("FAIL rnd_addr_stable@%0d: addr=%h required %h", cyc, imemAddr, prevAddr);
        end
      end
`ifdef IFU_STALL_COUNTER_EN
      if (((prevReq && !ackAtEdge) || (prevValid && !readyIn)) && expStall != 32'hFFFF_FFFF) expStall++;
      nChecks++;
      if (stallCycles !== expStall) begin
        nFails++; $display("FAIL rnd_stall@%0d: stallCycles=%0d required %0d", cyc, stallCycles, expStall);
      end
`endif
      prevValid = instrValid; prevReq = imemReq; prevPc = pcOut; prevInstr = instr; prevAddr = imemAddr;
      readyIn = ($urandom_range(0, 2) != 0);
      redirIn = ($urandom_range(0, 9) == 0);
      r = $urandom;
      tgtIn = ($urandom_range(0, 3) == 0) ? {30'h3FFF_FFFF, r[1:0]} : r;
      instrReady = readyIn; redirect = redirIn; redirectTarget = tgtIn;
    end
    instrReady = 1'b0; redirect = 1'b0;
    nChecks++;
    if (delivered < 50) begin
      nFails++; $display("FAIL rnd_progress: delivered=%0d required >=50", delivered);
    end
    $display("test_random done: delivered=%0d", delivered);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_drain();
    test_align();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main control decoder.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Registers the returned instruction and presents it, with opcode [31:26] and PC, to decode through a valid/ready handshake.
- Accepts a branch/jump redirect from execute; stale fetches are discarded.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32, PC / memory address width.

Ports:
- clk  input  1  sole clock; all state updates on posedge
- reset  input  1  asynchronous, active-high reset
- imemReq  output  1  fetch request; held high until imemAck
- imemAddr  output  ADDR_W  word-aligned fetch address; stable while imemReq=1
- imemRdata  input  32  instruction data; valid when imemAck=1
- imemAck  input  1  one-cycle completion strobe; ignored when imemReq=0
- instr  output  32  registered instruction
- opcode  output  6  instr[31:26], combinational from the instr register
- pcOut  output  ADDR_W  address of the held instr
- pcPlus4  output  ADDR_W  pcOut+4, modulo 2^ADDR_W
- instrValid  output  1  instr/pcOut valid for decode
- instrReady  input  1  decode accepts when instrValid & instrReady
- redirect  input  1  one-cycle taken-branch/jump strobe
- redirectTarget  input  ADDR_W  new PC; bits [1:0] forced to 00 internally

Behaviour:
- Reset (async, any state) values:
  - state=IDLE, pc=RESET_PC
  - imemReq=0, instrValid=0, instr=0, pcOut=RESET_PC
- FSM states: IDLE, REQ, DRAIN, HOLD.
- IDLE: unconditionally → REQ on the first clock after reset deasserts.
- REQ: imemReq=1, imemAddr=pc.
  - imemAck & !redirect: instr←imemRdata, pcOut←pc, pc←pc+4, instrValid←1 → HOLD.
  - redirect & imemAck (same cycle): data dropped, pc←target → REQ.
  - redirect & !imemAck: pc←target → DRAIN. The request stays high with the old address because the protocol forbids withdrawing a request.
- DRAIN:
  - imemReq=1, imemAddr = the old latched address.
  - On imemAck: data dropped → REQ.
  - A further redirect in DRAIN updates pc; the last redirect wins.
- HOLD: imemReq=0; instr, pcOut and instrValid are stable.
  - instrReady & !redirect: instrValid←0 → REQ, so the next request issues the following cycle.
  - redirect (priority over instrReady): instrValid←0, pc←target → REQ.
- Throughput: at most one instruction per 2 cycles plus memory latency. No prefetch beyond one outstanding request.
- PC arithmetic: pc+4 wraps 32'hFFFF_FFFC → 0. There is no misalignment trap, because inputs are force-aligned.
- Redirect in IDLE: pc←target; the first fetch uses the target.
- Ack outside REQ/DRAIN: ignored.

Optional Feature:
- Macro: IFU_STALL_COUNTER_EN.
- When defined:
  - Extra output stallCycles [31:0], reset 0.
  - Increments every cycle imemReq=1 & imemAck=0, plus every cycle in HOLD with instrReady=0.
  - Saturates at 32'hFFFF_FFFF.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - state encoding constants IFU_IDLE/REQ/DRAIN/HOLD (2 bits)
  - OPCODE_MSB=31, OPCODE_LSB=26
  - INSTR_BYTES=4
  - the opcode constants already used by the decoder (R-type 0, lw 6'b100011, sw 6'b101011, beq 6'b000100)
- One natural sub-module: pc_reg. It holds the async-reset PC register with load-target / increment / hold select and aligned-target masking.

Test Plan:
- Reset RESET_PC=32'h0000_0040, mem ack latency 1: first imemAddr=0x40; instrValid rises with instr=mem[0x40], opcode=6'b100011 for word 0x8C01_0004; next imemAddr=0x44.
- Decode back-pressure: instrReady=0 for 5 cycles in HOLD → instr, pcOut and instrValid unchanged and no new imemReq; on instrReady=1 the next request has addr pcOut+4.
- Redirect during outstanding fetch (ack latency 3) with target 0x100: the old address is acked and discarded with instrValid never set; the next imemAddr=0x100.
- Simultaneous redirect target 0x203 and instrReady in HOLD → instrValid falls; the next imemAddr=0x200, showing alignment.
- Wrap: RESET_PC=32'hFFFF_FFFC → after accept, the next imemAddr=0 and pcPlus4 of the first instr=0.
- Async reset asserted mid-DRAIN (no clock edge) → imemReq and instrValid drop immediately; after release, fetch restarts at RESET_PC; with IFU_STALL_COUNTER_EN, stallCycles=0.
